// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, default starvation limit and MDU buffer entry type
package wb_port_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;
endpackage

// File: rtl/wb_mdu_fifo.sv
// wb_mdu_fifo: 2-entry compacting MDU result buffer with head pop and per-register invalidate
module wb_mdu_fifo
  import wb_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_ent_t           push_ent,
  input  logic              pop,
  input  logic              inv,
  input  logic [ADDR_W-1:0] inv_rd,
  output wb_ent_t           head,
  output logic [1:0]        count
);
  wb_ent_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic v0_q, v0_d, v1_q, v1_d, keep0, keep1;
  // Drop popped/invalidated entries, slide survivors to the head, append the push behind them
  always_comb begin
    keep0  = v0_q && !pop && !(inv && ent0_q.rd == inv_rd);
    keep1  = v1_q && !(inv && ent1_q.rd == inv_rd);
    v0_d   = keep0 || keep1 || push;
    v1_d   = (keep0 && keep1) || ((keep0 ^ keep1) && push);
    ent0_d = keep0 ? ent0_q : keep1 ? ent1_q : push_ent;
    ent1_d = (keep0 && keep1) ? ent1_q : push_ent;
  end
  // Entry storage; reset discards everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end
  assign head  = ent0_q;
  assign count = {1'b0, v0_q} + {1'b0, v1_q};
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges MEM/WB and buffered MDU writes onto one register-file write port
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pipe_stall,
  output logic [1:0]        buf_count
);
  wb_ent_t head, mdu_ent;
  logic [1:0] count;
  logic pipe_act, fifo_gnt, push;
  logic rf_we_q, rf_we_d, pipe_stall_q, pipe_stall_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [3:0] cnt_q, cnt_d;
  assign mdu_ent = '{rd: mdu_rd, data: mdu_data};
  assign mdu_ready = count != 2'd2;
  wb_mdu_fifo u_fifo (
    .clk(clk), .reset(reset), .push(push), .push_ent(mdu_ent), .pop(fifo_gnt),
    .inv(pipe_act), .inv_rd(wb_rd), .head(head), .count(count)
  );
  // Pipe wins unless stalled; buffered head goes otherwise; starvation forces a one-cycle stall
  always_comb begin
    pipe_act     = wb_regwrite && wb_rd != '0 && !pipe_stall_q;
    fifo_gnt     = !pipe_act && count != 2'd0;
    push         = mdu_valid && mdu_ready && mdu_rd != '0;
    rf_we_d      = pipe_act || fifo_gnt;
    rf_waddr_d   = pipe_act ? wb_rd : fifo_gnt ? head.rd : rf_waddr_q;
    rf_wdata_d   = pipe_act ? wb_data : fifo_gnt ? head.data : rf_wdata_q;
    pipe_stall_d = cnt_q == 4'(STARVE_LIMIT);
    cnt_d        = (pipe_stall_d || fifo_gnt || count == 2'd0) ? 4'd0 : cnt_q + 4'd1;
  end
  // Registered write port, stall request and starvation counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pipe_stall_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pipe_stall_q <= pipe_stall_d;
      cnt_q        <= cnt_d;
    end
  end
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = pipe_stall_q;
  assign buf_count  = count;
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive un-granted cycles a buffered MDU result tolerates before a pipeline stall is forced (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 wb_regwrite  input  1  MEM/WB stage register-write request.
REQ-005 wb_rd  input  5  MEM/WB destination register.
REQ-006 wb_data  input  32  MEM/WB write data.
REQ-007 mdu_valid  input  1  multiply/divide unit result valid.
REQ-008 mdu_rd  input  5  MDU destination register.
REQ-009 mdu_data  input  32  MDU result data.
REQ-010 mdu_ready  output  1  arbiter can accept an MDU result this cycle.
REQ-011 rf_we  output  1  register-file write enable, registered.
REQ-012 rf_waddr  output  5  register-file write address, registered.
REQ-013 rf_wdata  output  32  register-file write data, registered.
REQ-014 pipe_stall  output  1  registered request for the pipeline to hold MEM/WB for one cycle.
REQ-015 buf_count  output  2  number of valid MDU entries buffered (0..2).

Function
REQ-016 A pipe request SHALL be active when wb_regwrite=1, wb_rd!=0 and pipe_stall=0; wb_* inputs are ignored while pipe_stall=1.
REQ-017 The MDU result path SHALL be a 2-entry FIFO; mdu_ready = (buf_count<2), combinational from state only; push on mdu_valid && mdu_ready.
REQ-018 MDU results with mdu_rd=0 SHALL be accepted (handshake completes) and discarded, never occupying an entry.
REQ-019 Each cycle, grant order: active pipe request first; otherwise the FIFO head if buf_count>0; otherwise no grant.
REQ-020 The granted write SHALL appear on rf_we/rf_waddr/rf_wdata on the following rising edge (latency 1); with no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
REQ-021 A granted FIFO head SHALL be popped in the same edge; push and pop in one cycle SHALL leave buf_count unchanged.
REQ-022 When a pipe write to register X is granted, every buffered entry targeting X SHALL be invalidated in the same edge (pipe write is younger); invalidated entries are removed and buf_count decremented accordingly.
REQ-023 A starvation counter (4 bits) SHALL increment each cycle buf_count>0 and the FIFO is not granted, and clear to 0 on any FIFO grant or when buf_count=0.
REQ-024 When the counter equals STARVE_LIMIT, pipe_stall SHALL be 1 in the next cycle and the counter SHALL clear; during that cycle the FIFO head is granted.
REQ-025 pipe_stall SHALL never be high for two consecutive cycles.
REQ-026 An MDU push arriving while buf_count=0 SHALL not be granted in the same cycle; earliest rf write is 2 edges after the push.

Reset
REQ-027 While reset=0: rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, buf_count=0, counter=0, FIFO entries invalid, mdu_ready=1 after the first edge following release.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries without producing an rf write.

Structure
REQ-029 A shared package SHALL hold the register-address width (5), data width (32) and the STARVE_LIMIT default.
REQ-030 The 2-entry FIFO with per-entry invalidate SHALL be a sub-module named wb_mdu_fifo; arbitration and starvation logic stay in wb_port_arbiter.

Verification
REQ-031 Pipe only: wb_regwrite=1, wb_rd=5, wb_data=0x1234 -> next edge rf_we=1, rf_waddr=5, rf_wdata=0x1234; wb_rd=0 -> rf_we=0.
REQ-032 MDU only: mdu_valid=1, mdu_rd=9, mdu_data=0xCAFE, no pipe traffic -> buf_count=1, then rf write of reg 9 = 0xCAFE 2 edges after push, buf_count returns to 0.
REQ-033 Full: three back-to-back MDU results under continuous pipe writes -> mdu_ready=0 after 2 accepted, third held until a pop.
REQ-034 Starvation: one buffered entry plus continuous pipe writes, STARVE_LIMIT=4 -> pipe_stall=1 exactly one cycle after 4 un-granted cycles, buffered entry written that cycle, pipe write to same register re-presented and written the cycle after.
REQ-035 WAW: buffered entry rd=7, then pipe write rd=7 data 0x55 -> entry dropped, reg 7 final value 0x55, buf_count=0.
REQ-036 Reset mid-operation with buf_count=2 -> all outputs 0, no rf write after release.
